// File: rtl/tmr_error_checker.sv
// -----------------------------------------------------------------------------
// tmr_error_checker
//
// Lockstep checker for three redundant cores. Each cycle the retire packets of
// the three cores are masked down to their relevant fields, registered, then
// compared pairwise and majority-voted. A single outvoted core produces a
// one-cycle error pulse and the checker then waits for the recovery controller
// to signal resume. A three-way disagreement is unrecoverable and latches a
// sticky fatal flag until reset.
//
// Ports:
//   clk_i          clock, rising-edge active
//   rst_ni         asynchronous active-low reset
//   valid_i[2:0]   retire-valid per core (bit k = core k)
//   we_i[2:0]      write-back enable per core
//   pc_i           retired PC per core, core k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wb_addr_i      write-back register address per core
//   wb_data_i      write-back data per core
//   resume_i       recovery-complete pulse from the recovery controller
//   error_o        one-cycle error pulse to the recovery controller
//   faulty_core_o  index of the outvoted core, 2'b11 = none
//   fatal_o        sticky unrecoverable-disagreement flag
//   err_count_o    saturating count of detected errors
// -----------------------------------------------------------------------------
module tmr_error_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [2:0]              valid_i,
  input  logic [2:0]              we_i,
  input  logic [3*DATA_WIDTH-1:0] pc_i,
  input  logic [3*ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [3*DATA_WIDTH-1:0] wb_data_i,
  input  logic                    resume_i,
  output logic                    error_o,
  output logic [1:0]              faulty_core_o,
  output logic                    fatal_o,
  output logic [CNT_WIDTH-1:0]    err_count_o
);

  localparam int LOW_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int PKT_W = 2 + DATA_WIDTH + LOW_W;

  typedef enum logic [1:0] {
    CHECK   = 2'd0,
    RECOVER = 2'd1,
    FATAL   = 2'd2
  } state_t;

  state_t state;

  // Irrelevant fields are forced to zero so a plain equality compare of the
  // masked packets implements the field-masking rules.
  function automatic logic [PKT_W-1:0] mask_pkt(
    input logic                  v,
    input logic                  w,
    input logic [DATA_WIDTH-1:0] pc,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [PKT_W-1:0] p;
    if (!v)      p = '0;
    else if (!w) p = {1'b1, 1'b0, pc, {LOW_W{1'b0}}};
    else         p = {1'b1, 1'b1, pc, addr, data};
    return p;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // ---- Stage 1: masked packet registers ----
  logic [PKT_W-1:0] pkt_p1 [3];
  logic             vld_p1;
  logic             hit;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 3; k++) begin
      pkt_p1[k] <= mask_pkt(valid_i[k], we_i[k],
                            pc_i[k*DATA_WIDTH +: DATA_WIDTH],
                            wb_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
                            wb_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // The packet captured on the edge that reports an error, and every packet
  // captured outside CHECK, is never allowed to be voted on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_p1 <= 1'b0;
    else         vld_p1 <= (state == CHECK) && !hit;
  end

  // ---- Stage 2: pairwise compare and majority vote ----
  logic       eq01, eq02, eq12;
  logic       vote_single, vote_fatal;
  logic [1:0] vote_core;

  assign eq01 = (pkt_p1[0] == pkt_p1[1]);
  assign eq02 = (pkt_p1[0] == pkt_p1[2]);
  assign eq12 = (pkt_p1[1] == pkt_p1[2]);

  // Equality is transitive, so at most one pair can match when not all agree.
  always_comb begin
    vote_single = 1'b0;
    vote_fatal  = 1'b0;
    vote_core   = 2'b11;
    if (!(eq01 && eq02)) begin
      if (eq01) begin
        vote_single = 1'b1;
        vote_core   = 2'd2;
      end else if (eq02) begin
        vote_single = 1'b1;
        vote_core   = 2'd1;
      end else if (eq12) begin
        vote_single = 1'b1;
        vote_core   = 2'd0;
      end else begin
        vote_fatal  = 1'b1;
      end
    end
  end

  assign hit = vld_p1 && (vote_single || vote_fatal);

  // ---- Control FSM with registered outputs ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= CHECK;
      error_o       <= 1'b0;
      faulty_core_o <= 2'b11;
      fatal_o       <= 1'b0;
      err_count_o   <= '0;
    end else begin
      error_o <= 1'b0;
      case (state)
        CHECK: begin
          if (vld_p1 && vote_fatal) begin
            error_o     <= 1'b1;
            fatal_o     <= 1'b1;
            err_count_o <= sat_inc(err_count_o);
            state       <= FATAL;
          end else if (vld_p1 && vote_single) begin
            error_o       <= 1'b1;
            faulty_core_o <= vote_core;
            err_count_o   <= sat_inc(err_count_o);
            state         <= RECOVER;
          end
        end
        RECOVER: begin
          // Vote results are ignored here; only resume matters.
          if (resume_i) begin
            faulty_core_o <= 2'b11;
            state         <= CHECK;
          end
        end
        FATAL: begin
          state <= FATAL;
        end
        default: begin
          state <= CHECK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_error_checker.sv
// -----------------------------------------------------------------------------
// tb_tmr_error_checker
//
// Directed and randomized stimulus for tmr_error_checker, checked every cycle
// against a behavioural model of the checker's rules (field-level agreement,
// vote, one-cycle result latency, recover/fatal behaviour, saturating count).
// -----------------------------------------------------------------------------
module tb_tmr_error_checker;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          resume;
  logic [2:0]    valid, we;
  logic [DW-1:0] pc   [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] data [3];

  logic [3*DW-1:0] pc_bus, data_bus;
  logic [3*AW-1:0] addr_bus;
  assign pc_bus   = {pc[2], pc[1], pc[0]};
  assign data_bus = {data[2], data[1], data[0]};
  assign addr_bus = {addr[2], addr[1], addr[0]};

  logic          error;
  logic [1:0]    faulty;
  logic          fatal;
  logic [CW-1:0] count;

  tmr_error_checker #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid),
    .we_i         (we),
    .pc_i         (pc_bus),
    .wb_addr_i    (addr_bus),
    .wb_data_i    (data_bus),
    .resume_i     (resume),
    .error_o      (error),
    .faulty_core_o(faulty),
    .fatal_o      (fatal),
    .err_count_o  (count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // mode: 0 = checking, 1 = waiting for resume, 2 = dead until reset
  typedef struct {
    int due;
    int kind;   // 0 agree, 1 single outvoted core, 2 no majority
    int core;
  } verdict_t;

  verdict_t   pend[$];
  int         mode;
  int         cyc = 0;
  logic       m_err;
  logic [1:0] m_faulty;
  logic       m_fatal;
  int         m_cnt;

  // Two cores agree when every field that matters for their retire agrees.
  function automatic bit agree(int a, int b);
    if (valid[a] != valid[b]) return 1'b0;
    if (!valid[a]) return 1'b1;
    if (we[a] != we[b] || pc[a] != pc[b]) return 1'b0;
    if (!we[a]) return 1'b1;
    return (addr[a] == addr[b]) && (data[a] == data[b]);
  endfunction

  function automatic verdict_t judge();
    verdict_t r;
    int n;
    r.due  = 0;
    r.core = 3;
    n = int'(agree(0, 1)) + int'(agree(0, 2)) + int'(agree(1, 2));
    if (n == 3)      r.kind = 0;
    else if (n == 0) r.kind = 2;
    else begin
      r.kind = 1;
      for (int k = 0; k < 3; k++) begin
        if (agree((k + 1) % 3, (k + 2) % 3) && !agree(k, (k + 1) % 3)) r.core = k;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    mode     = 0;
    m_err    = 1'b0;
    m_faulty = 2'b11;
    m_fatal  = 1'b0;
    m_cnt    = 0;
    pend.delete();
  endtask

  task automatic bump();
    if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
  endtask

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    verdict_t r;
    int old_mode;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_mode = mode;
    m_err    = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (old_mode == 0 && r.kind == 1) begin
        m_err = 1'b1; m_faulty = 2'(r.core); bump(); mode = 1;
      end else if (old_mode == 0 && r.kind == 2) begin
        m_err = 1'b1; m_fatal = 1'b1; bump(); mode = 2;
      end
    end
    if (old_mode == 1 && resume) begin
      m_faulty = 2'b11;
      mode     = 0;
    end
    // Only samples taken while checking, and not on the reporting edge, count.
    if (old_mode == 0 && mode == 0) begin
      r     = judge();
      r.due = cyc + 1;
      pend.push_back(r);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check();
    vectors++;
    assert (error === m_err) else begin
      miscompares++;
      $error("FAIL error_o cyc %0d: observed %0b expected %0b", cyc, error, m_err);
    end
    assert (faulty === m_faulty) else begin
      miscompares++;
      $error("FAIL faulty_core_o cyc %0d: observed %0d expected %0d", cyc, faulty, m_faulty);
    end
    assert (fatal === m_fatal) else begin
      miscompares++;
      $error("FAIL fatal_o cyc %0d: observed %0b expected %0b", cyc, fatal, m_fatal);
    end
    assert (count === m_cnt[CW-1:0]) else begin
      miscompares++;
      $error("FAIL err_count_o cyc %0d: observed %0d expected %0d", cyc, count, m_cnt);
    end
  endtask

  task automatic expect_out(input string tag, input logic e, input logic [1:0] f,
                            input logic ft, input int c);
    assert (error === e) else begin
      miscompares++;
      $error("FAIL %s error_o: observed %0b expected %0b", tag, error, e);
    end
    assert (faulty === f) else begin
      miscompares++;
      $error("FAIL %s faulty_core_o: observed %0d expected %0d", tag, faulty, f);
    end
    assert (fatal === ft) else begin
      miscompares++;
      $error("FAIL %s fatal_o: observed %0b expected %0b", tag, fatal, ft);
    end
    assert (count === c[CW-1:0]) else begin
      miscompares++;
      $error("FAIL %s err_count_o: observed %0d expected %0d", tag, count, c);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check();
  endtask

  // Called 1 time unit after an edge: reset asserts and releases mid-cycle.
  task automatic do_async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check();
    #2 rst_n = 1'b1;
  endtask

  task automatic set_all(input logic [DW-1:0] p, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic w);
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b1;
      we[k]    = w;
      pc[k]    = p;
      addr[k]  = a;
      data[k]  = d;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] bpc, bdata;
    logic [AW-1:0] baddr;
    logic          bv, bw;
    int            stuck;

    rst_n  = 1'b0;
    resume = 1'b0;
    model_reset();
    set_all(32'h100, 5'd5, 32'hDEADBEEF, 1'b1);
    tick();
    tick();
    expect_out("reset", 1'b0, 2'b11, 1'b0, 0);
    #2 rst_n = 1'b1;

    // Identical packets
    repeat (50) tick();
    expect_out("identical", 1'b0, 2'b11, 1'b0, 0);

    // Single fault on core 1, persisting, then resume
    data[1] = 32'hDEADBEEE;
    tick();
    tick();
    expect_out("fault_core1", 1'b1, 2'd1, 1'b0, 1);
    repeat (10) tick();
    expect_out("fault_hold", 1'b0, 2'd1, 1'b0, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    expect_out("resume", 1'b0, 2'b11, 1'b0, 1);
    tick();
    tick();
    expect_out("restart_r2", 1'b1, 2'd1, 1'b0, 2);
    data[1] = 32'hDEADBEEF;
    resume  = 1'b1;
    tick();
    resume  = 1'b0;
    repeat (3) tick();

    // Masked fields
    do_async_reset();
    set_all(32'h200, 5'd3, 32'h1234, 1'b0);
    data[0] = 32'h9999;
    repeat (5) tick();
    expect_out("mask_we", 1'b0, 2'b11, 1'b0, 0);
    set_all(32'h200, 5'd3, 32'h1234, 1'b1);
    valid[2] = 1'b0;
    tick();
    tick();
    expect_out("mask_valid", 1'b1, 2'd2, 1'b0, 1);
    valid[2] = 1'b1;
    resume   = 1'b1;
    tick();
    resume   = 1'b0;
    tick();

    // Three-way mismatch
    do_async_reset();
    set_all(32'h10, 5'd1, 32'h55, 1'b1);
    pc[1] = 32'h14;
    pc[2] = 32'h18;
    tick();
    tick();
    expect_out("fatal", 1'b1, 2'b11, 1'b1, 1);
    tick();
    expect_out("fatal_hold", 1'b0, 2'b11, 1'b1, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    repeat (3) tick();
    expect_out("fatal_resume", 1'b0, 2'b11, 1'b1, 1);
    do_async_reset();
    expect_out("fatal_reset", 1'b0, 2'b11, 1'b0, 0);

    // Saturation
    for (int i = 1; i <= 4; i++) begin
      set_all(32'h300, 5'd7, 32'hCAFE, 1'b1);
      tick();
      data[0] = 32'hCAFF;
      tick();
      tick();
      expect_out("saturate", 1'b1, 2'd0, 1'b0, (i < 3) ? i : 3);
      data[0] = 32'hCAFE;
      resume  = 1'b1;
      tick();
      resume  = 1'b0;
    end
    tick();

    // Resume collision, then reset mid-recover
    do_async_reset();
    set_all(32'h400, 5'd9, 32'hABCD, 1'b1);
    tick();
    data[2] = 32'hABCC;
    tick();
    tick();
    expect_out("collide_err", 1'b1, 2'd2, 1'b0, 1);
    tick();
    resume = 1'b1;
    tick();
    resume  = 1'b0;
    data[2] = 32'hABCD;
    expect_out("collide", 1'b0, 2'b11, 1'b0, 1);
    repeat (3) tick();
    expect_out("collide_after", 1'b0, 2'b11, 1'b0, 1);
    data[2] = 32'h0;
    tick();
    tick();
    tick();
    expect_out("recover_pre", 1'b0, 2'd2, 1'b0, 2);
    do_async_reset();
    expect_out("recover_reset", 1'b0, 2'b11, 1'b0, 0);

    // Randomized traffic
    stuck = 0;
    for (int i = 0; i < 600; i++) begin
      bpc   = $urandom;
      bdata = $urandom;
      baddr = AW'($urandom_range(31, 0));
      bv    = ($urandom_range(7, 0) != 0);
      bw    = 1'($urandom_range(1, 0));
      for (int k = 0; k < 3; k++) begin
        valid[k] = bv;
        we[k]    = bw;
        pc[k]    = bpc;
        addr[k]  = baddr;
        data[k]  = bdata;
        if ($urandom_range(7, 0) == 0) begin
          case ($urandom_range(4, 0))
            0: valid[k] = !valid[k];
            1: we[k]    = !we[k];
            2: pc[k]    = pc[k] ^ (32'h1 << $urandom_range(31, 0));
            3: addr[k]  = addr[k] ^ AW'(1 << $urandom_range(4, 0));
            default: data[k] = data[k] ^ (32'h1 << $urandom_range(31, 0));
          endcase
        end
      end
      resume = ($urandom_range(4, 0) == 0);
      tick();
      if (mode == 2) stuck++;
      else           stuck = 0;
      if (stuck > 3 || $urandom_range(99, 0) == 0) begin
        do_async_reset();
        stuck = 0;
      end
    end
    resume = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
